seg_display_arbiter: RTL and testbench



---
 rtl/seg_display_arbiter_if.sv | 22 ++
 rtl/seg_display_arbiter.sv | 121 ++++++++++++
 tb/tb_seg_display_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/seg_display_arbiter_if.sv
// Request/grant bundle between the per-function pattern generators and the
// 7-segment display arbiter.
interface seg_display_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]   req;
   logic [NREQ*8-1:0] pat;
   logic [NREQ-1:0]   gnt;
   logic [7:0]        SEG;
   logic              busy;
   logic [2:0]        cur_idx;

   modport master (
      output req, pat,
      input  gnt, SEG, busy, cur_idx
   );

   modport slave (
      input  req, pat,
      output gnt, SEG, busy, cur_idx
   );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing the single 8-bit SEG output between NREQ
// pattern generators, holding each grant for up to HOLD_CYCLES clk_2 cycles.
//
// state | meaning
// IDLE  | nobody granted, SEG shows BLANK
// SHOW  | requester cur owns SEG, dwell counter cnt running
module seg_display_arbiter #(
   parameter int         NREQ        = 4,
   parameter int         HOLD_CYCLES = 4,
   parameter logic [7:0] BLANK       = 8'h00
) (
   input  logic                clk_2,
   input  logic                reset,
   seg_display_arbiter_if.slave bus
);
   localparam int CW = $clog2(HOLD_CYCLES) + 1;

   typedef enum logic {IDLE, SHOW} state_t;

   state_t          state;
   logic [NREQ-1:0] gnt_r;
   logic [7:0]      seg_r;
   logic            busy_r;
   logic [2:0]      cur;
   logic [2:0]      ptr;
   logic [CW-1:0]   cnt;

   logic [2:0]      next_ptr;
   logic [2:0]      start_idx;
   logic [3:0]      hit;
   logic            end_cond;

   // Returns {found, index}: nearest set request at or after start, wrapping.
   function automatic logic [3:0] pick(input logic [NREQ-1:0] r, input logic [2:0] start);
      int         best_d;
      int         d;
      logic [2:0] idx;
      best_d = NREQ;
      idx    = 3'd0;
      for (int i = 0; i < NREQ; i++) begin
         if (r[i]) begin
            d = (i - int'(start) + NREQ) % NREQ;
            if (d < best_d) begin
               best_d = d;
               idx    = 3'(i);
            end
         end
      end
      return {(best_d < NREQ), idx};
   endfunction

   function automatic logic [7:0] pat_of(input logic [NREQ*8-1:0] p, input logic [2:0] idx);
      logic [7:0] v;
      v = 8'h00;
      for (int i = 0; i < NREQ; i++) begin
         if (3'(i) == idx) v = p[8*i +: 8];
      end
      return v;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input logic [2:0] idx);
      return {{(NREQ-1){1'b0}}, 1'b1} << idx;
   endfunction

   assign next_ptr  = (cur == 3'(NREQ-1)) ? 3'd0 : cur + 3'd1;
   // Leaving SHOW searches from the rotated pointer before it is registered.
   assign start_idx = (state == SHOW) ? next_ptr : ptr;
   assign hit       = pick(bus.req, start_idx);
   assign end_cond  = (cnt == CW'(HOLD_CYCLES-1)) || !(|(bus.req & gnt_r));

   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         gnt_r  <= '0;
         seg_r  <= BLANK;
         busy_r <= 1'b0;
         cur    <= 3'd0;
         ptr    <= 3'd0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (hit[3]) begin
                  state  <= SHOW;
                  cur    <= hit[2:0];
                  gnt_r  <= onehot(hit[2:0]);
                  seg_r  <= pat_of(bus.pat, hit[2:0]);
                  busy_r <= 1'b1;
                  cnt    <= '0;
               end
            end
            SHOW: begin
               if (!end_cond) begin
                  cnt   <= cnt + CW'(1);
                  seg_r <= pat_of(bus.pat, cur);
               end else begin
                  ptr <= next_ptr;
                  cnt <= '0;
                  if (hit[3]) begin
                     cur   <= hit[2:0];
                     gnt_r <= onehot(hit[2:0]);
                     seg_r <= pat_of(bus.pat, hit[2:0]);
                  end else begin
                     state  <= IDLE;
                     cur    <= 3'd0;
                     gnt_r  <= '0;
                     seg_r  <= BLANK;
                     busy_r <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.gnt     = gnt_r;
   assign bus.SEG     = seg_r;
   assign bus.busy    = busy_r;
   assign bus.cur_idx = cur;
endmodule

// File: tb/tb_seg_display_arbiter.sv
// Randomized and directed checks of seg_display_arbiter against a
// behavioural round-robin model.
module tb_seg_display_arbiter;
   localparam int NREQ = 4;
   localparam int HOLD = 4;

   logic clk_2;
   logic reset;

   seg_display_arbiter_if #(.NREQ(NREQ)) bus ();

   seg_display_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(HOLD), .BLANK(8'h00)) dut (
      .clk_2 (clk_2),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk_2 = 1'b0;
      forever #5 clk_2 = ~clk_2;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   // Model: current owner (-1 = nobody), dwell cycles used, rotation pointer.
   int         m_cur = -1;
   int         m_cnt = 0;
   int         m_ptr = 0;
   logic [7:0] m_seg = 8'h00;

   function automatic int first_from(input int p, input logic [NREQ-1:0] r);
      for (int k = 0; k < NREQ; k++)
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   always @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         m_cur = -1; m_cnt = 0; m_ptr = 0; m_seg = 8'h00;
      end else begin
         if (m_cur < 0) begin
            m_cur = first_from(m_ptr, bus.req);
            m_cnt = 0;
         end else if (m_cnt == HOLD - 1 || !bus.req[m_cur]) begin
            m_ptr = (m_cur + 1) % NREQ;
            m_cur = first_from(m_ptr, bus.req);
            m_cnt = 0;
         end else begin
            m_cnt = m_cnt + 1;
         end
         m_seg = (m_cur < 0) ? 8'h00 : bus.pat[8*m_cur +: 8];
      end
   end

   task automatic compare_model();
      logic [NREQ-1:0] eg;
      eg = (m_cur < 0) ? '0 : (NREQ'(1) << m_cur);
      check("gnt",     32'(bus.gnt),     32'(eg));
      check("SEG",     32'(bus.SEG),     32'(m_seg));
      check("busy",    32'(bus.busy),    32'(m_cur >= 0));
      check("cur_idx", 32'(bus.cur_idx), (m_cur < 0) ? 32'd0 : 32'(m_cur));
   endtask

   task automatic tick();
      @(posedge clk_2);
      #1;
      compare_model();
   endtask

   task automatic do_reset();
      #2 reset = 1'b1;
      #2 reset = 1'b0;
   endtask

   task automatic set_pat(input int i, input logic [7:0] v);
      bus.pat[8*i +: 8] = v;
   endtask

   initial begin
      reset   = 1'b1;
      bus.req = '0;
      bus.pat = {8'h3F, 8'h73, 8'h71, 8'h77};
      #12 reset = 1'b0;
      @(posedge clk_2); #1;
      check("rst_gnt", 32'(bus.gnt), 32'd0);
      check("rst_seg", 32'(bus.SEG), 32'd0);

      // async reset while requester 2 is shown
      bus.req = 4'b0100;
      tick();
      check("r2_gnt", 32'(bus.gnt), 32'b0100);
      #3 reset = 1'b1;
      #1;
      check("async_gnt",  32'(bus.gnt),  32'd0);
      check("async_seg",  32'(bus.SEG),  32'd0);
      check("async_busy", 32'(bus.busy), 32'd0);
      #1 reset = 1'b0;
      bus.req = '0;
      repeat (3) tick();
      check("post_rst_gnt", 32'(bus.gnt), 32'd0);

      // single requester: continuous self re-grant
      bus.req = 4'b0001;
      set_pat(0, 8'b01110111);
      for (int c = 0; c < 20; c++) begin
         tick();
         check("solo_gnt", 32'(bus.gnt), 32'b0001);
         check("solo_seg", 32'(bus.SEG), 32'b01110111);
      end

      // full rotation from a fresh pointer
      do_reset();
      bus.pat = {8'h3F, 8'h73, 8'h71, 8'h77};
      bus.req = 4'b1111;
      for (int j = 0; j < 17; j++) begin
         logic [31:0] pats;
         tick();
         pats = {8'h3F, 8'h73, 8'h71, 8'h77};
         check("rot_gnt", 32'(bus.gnt), 32'(1) << ((j / HOLD) % NREQ));
         check("rot_seg", 32'(bus.SEG), 32'(pats[8*((j / HOLD) % NREQ) +: 8]));
      end

      // early release of requester 1 at cnt=1
      do_reset();
      bus.req = 4'b1010;
      tick();
      check("er_gnt1", 32'(bus.gnt), 32'b0010);
      tick();
      bus.req = 4'b1000;
      tick();
      check("er_gnt3", 32'(bus.gnt), 32'b1000);
      check("er_seg3", 32'(bus.SEG), 32'h3F);

      // idle return and pointer wrap
      do_reset();
      bus.req = 4'b1000;
      tick();
      tick();
      bus.req = 4'b0000;
      tick();
      check("idle_gnt",  32'(bus.gnt),     32'd0);
      check("idle_seg",  32'(bus.SEG),     32'd0);
      check("idle_busy", 32'(bus.busy),    32'd0);
      check("idle_idx",  32'(bus.cur_idx), 32'd0);
      bus.req = 4'b0101;
      tick();
      check("wrap_gnt", 32'(bus.gnt), 32'b0001);

      // live pattern update during a dwell
      do_reset();
      set_pat(0, 8'h77);
      bus.req = 4'b0001;
      tick();
      tick();
      set_pat(0, 8'h71);
      tick();
      check("live_seg", 32'(bus.SEG), 32'h71);
      check("live_gnt", 32'(bus.gnt), 32'b0001);

      // randomized traffic, model compared every edge
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) bus.req = NREQ'($urandom);
         if ($urandom_range(0, 2) == 0) set_pat($urandom_range(0, NREQ-1), 8'($urandom));
         if (c == 200) begin
            #2 reset = 1'b1;
            #1;
            check("rand_rst_gnt", 32'(bus.gnt), 32'd0);
            #1 reset = 1'b0;
         end
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
